eth_top: RTL and testbench

- FPGA top level for a two-port RMII Ethernet repeater board running from one 200 MHz oscillator.
- Generates the 50 MHz RMII reference clock and the PHY reset for both PHYs.
- Forwards every received RMII frame from each port to the other, and counts the frames.
- Reports counters on the LEDs and over a 115200-baud UART, on button press or on UART command.

---
 rtl/eth_top_pkg.sv | 9 +
 rtl/eth_top_rmii_lane.sv | 44 ++++
 rtl/eth_top.sv | 170 +++++++++++++++++
 tb/tb_eth_top.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/eth_top_pkg.sv
// eth_top_pkg: shared constants and state type for the RMII repeater top level
package eth_top_pkg;
  localparam logic [7:0] CMD_CLEAR = 8'h43;
  localparam logic [7:0] CMD_STATUS = 8'h53;
  localparam int REPORT_LEN = 3;
  localparam logic [1:0] RMII_IDLE = 2'b00;
  localparam logic [1:0] RMII_ERR = 2'b01;
  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_st_t;
endpackage

// File: rtl/eth_top_rmii_lane.sv
// rmii_lane: one repeater direction with error substitution and frame-start counting
module rmii_lane
  import eth_top_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       en,
  input  logic       clr,
  input  logic       crs_dv,
  input  logic       rx_er,
  input  logic [1:0] rx_d,
  output logic       tx_e,
  output logic [1:0] tx_d,
  output logic       err,
  output logic [7:0] frames
);
  logic dv_q;
  logic smp;
  assign smp = ce && en;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx_e <= 1'b0;
      tx_d <= RMII_IDLE;
      dv_q <= 1'b0;
      err <= 1'b0;
    end else begin
      err <= smp && crs_dv && rx_er;
      if (!en) begin
        tx_e <= 1'b0;
        tx_d <= RMII_IDLE;
        dv_q <= 1'b0;
      end else if (ce) begin
        tx_e <= crs_dv;
        tx_d <= !crs_dv ? RMII_IDLE : rx_er ? RMII_ERR : rx_d;
        dv_q <= crs_dv;
      end
    end
  // clear has priority over a coincident frame start
  always_ff @(posedge clk or posedge rst)
    if (rst) frames <= '0;
    else if (clr) frames <= '0;
    else if (smp && crs_dv && !dv_q) frames <= frames + 8'd1;
endmodule

// File: rtl/eth_top.sv
// eth_top: two-port RMII repeater with 50 MHz PHY clocking, frame counters and UART status reports
module eth_top
  import eth_top_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1736,
  parameter int PHY_RST_CYCLES = 1000,
  parameter int BTN_SYNC_STAGES = 2
) (
  input  logic       clk_200_mhz,
  input  logic       rst,
  output logic       uart_tx,
  input  logic       uart_rx,
  input  logic       crs_dv_1,
  input  logic       crs_dv_2,
  input  logic       rx_er_1,
  input  logic       rx_er_2,
  input  logic [1:0] rx_d_1,
  input  logic [1:0] rx_d_2,
  output logic [1:0] tx_d_1,
  output logic [1:0] tx_d_2,
  output logic       tx_e_1,
  output logic       tx_e_2,
  output logic       mdc_1,
  output logic       mdc_2,
  inout  wire        mdio_1,
  inout  wire        mdio_2,
  output logic       clk_50_mhz_1,
  output logic       clk_50_mhz_2,
  output logic       rst_n_1,
  output logic       rst_n_2,
  input  logic       btn,
  output logic [7:0] led
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int RW = $clog2(PHY_RST_CYCLES + 1);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [RW-1:0] PHY_END = RW'(PHY_RST_CYCLES - 1);
  logic clk;
  logic [1:0] cnt;
  logic clk_50, ce, phy_rst_n;
  logic [RW-1:0] phy_cnt;
  logic [BTN_SYNC_STAGES-1:0] btn_sync, rx_sync;
  logic btn_s, rx_s, btn_q, rx_q, btn_rise, rx_fall;
  logic [7:0] frames_1, frames_2;
  logic err_1, err_2, err_flag, clr, req;
  uart_st_t rx_st, rx_nst, tx_st, tx_nst;
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic [2:0] rx_bit, tx_bit;
  logic [7:0] rx_sh;
  logic [8*REPORT_LEN-1:0] tx_sh;
  logic [1:0] tx_byte;
  logic rx_valid, rx_tick, tx_tick, tx_line;
  assign clk = clk_200_mhz;
  assign ce = cnt == 2'b11;
  assign clk_50_mhz_1 = clk_50;
  assign clk_50_mhz_2 = clk_50;
  assign rst_n_1 = phy_rst_n;
  assign rst_n_2 = phy_rst_n;
  assign mdc_1 = 1'b0;
  assign mdc_2 = 1'b0;
  assign mdio_1 = 1'bz;
  assign mdio_2 = 1'bz;
  assign led = {frames_2[3:0], frames_1[3:0]};
  assign btn_s = btn_sync[BTN_SYNC_STAGES-1];
  assign rx_s = rx_sync[BTN_SYNC_STAGES-1];
  assign btn_rise = btn_s && !btn_q;
  assign rx_fall = rx_q && !rx_s;
  assign clr = rx_valid && rx_sh == CMD_CLEAR;
  assign req = btn_rise || (rx_valid && rx_sh == CMD_STATUS);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= 2'd0;
      clk_50 <= 1'b0;
      phy_cnt <= '0;
      phy_rst_n <= 1'b0;
    end else begin
      cnt <= cnt + 2'd1;
      clk_50 <= cnt[1];
      if (phy_cnt == PHY_END) phy_rst_n <= 1'b1;
      else phy_cnt <= phy_cnt + 1'b1;
    end
  // the serial line idles high, so its synchroniser resets to ones
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      btn_sync <= '0;
      rx_sync <= '1;
      btn_q <= 1'b0;
      rx_q <= 1'b1;
    end else begin
      btn_sync <= BTN_SYNC_STAGES'({btn_sync, btn});
      rx_sync <= BTN_SYNC_STAGES'({rx_sync, uart_rx});
      btn_q <= btn_s;
      rx_q <= rx_s;
    end
  rmii_lane lane_12 (
    .clk(clk), .rst(rst), .ce(ce), .en(phy_rst_n), .clr(clr),
    .crs_dv(crs_dv_1), .rx_er(rx_er_1), .rx_d(rx_d_1),
    .tx_e(tx_e_2), .tx_d(tx_d_2), .err(err_1), .frames(frames_1)
  );
  rmii_lane lane_21 (
    .clk(clk), .rst(rst), .ce(ce), .en(phy_rst_n), .clr(clr),
    .crs_dv(crs_dv_2), .rx_er(rx_er_2), .rx_d(rx_d_2),
    .tx_e(tx_e_1), .tx_d(tx_d_1), .err(err_2), .frames(frames_2)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) err_flag <= 1'b0;
    else if (clr) err_flag <= 1'b0;
    else if (err_1 || err_2) err_flag <= 1'b1;
  always_comb begin
    rx_tick = rx_cnt == (rx_st == U_START ? HALF_END : BIT_END);
    rx_nst = rx_st;
    case (rx_st)
      U_IDLE: if (rx_fall) rx_nst = U_START;
      U_START: if (rx_tick) rx_nst = rx_s ? U_IDLE : U_DATA;
      U_DATA: if (rx_tick && rx_bit == 3'd7) rx_nst = U_STOP;
      default: if (rx_tick) rx_nst = U_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_st <= U_IDLE;
      rx_cnt <= '0;
      rx_bit <= 3'd0;
      rx_sh <= 8'd0;
      rx_valid <= 1'b0;
    end else begin
      rx_st <= rx_nst;
      rx_cnt <= (rx_st == U_IDLE || rx_tick) ? '0 : rx_cnt + 1'b1;
      rx_valid <= rx_st == U_STOP && rx_tick && rx_s;
      if (rx_st == U_DATA && rx_tick) begin
        rx_sh <= {rx_s, rx_sh[7:1]};
        rx_bit <= rx_bit + 3'd1;
      end
    end
  // requests are only accepted when idle, so one arriving mid-report is dropped
  always_comb begin
    tx_tick = tx_cnt == BIT_END;
    tx_line = tx_st == U_START ? 1'b0 : tx_st == U_DATA ? tx_sh[0] : 1'b1;
    tx_nst = tx_st;
    case (tx_st)
      U_IDLE: if (req) tx_nst = U_START;
      U_START: if (tx_tick) tx_nst = U_DATA;
      U_DATA: if (tx_tick && tx_bit == 3'd7) tx_nst = U_STOP;
      default: if (tx_tick) tx_nst = tx_byte == 2'(REPORT_LEN - 1) ? U_IDLE : U_START;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx_st <= U_IDLE;
      tx_cnt <= '0;
      tx_bit <= 3'd0;
      tx_byte <= 2'd0;
      tx_sh <= '0;
      uart_tx <= 1'b1;
    end else begin
      tx_st <= tx_nst;
      tx_cnt <= (tx_st == U_IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
      uart_tx <= tx_line;
      if (tx_st == U_IDLE && req) begin
        tx_sh <= {7'b0, err_flag, frames_2, frames_1};
        tx_byte <= 2'd0;
      end
      if (tx_st == U_DATA && tx_tick) begin
        tx_sh <= tx_sh >> 1;
        tx_bit <= tx_bit + 3'd1;
      end
      if (tx_st == U_STOP && tx_tick) tx_byte <= tx_byte + 2'd1;
    end
endmodule

// File: tb/tb_eth_top.sv
// tb_eth_top: scoreboard bench for the RMII repeater, frame counters and UART reports
`timescale 1ns/1ps
module tb_eth_top;
  import eth_top_pkg::*;
  localparam int CB = 40;
  logic clk = 1'b0, rst = 1'b1, uart_rx = 1'b1, btn = 1'b0;
  logic crs_dv_1 = 1'b0, crs_dv_2 = 1'b0, rx_er_1 = 1'b0, rx_er_2 = 1'b0;
  logic [1:0] rx_d_1 = 2'b00, rx_d_2 = 2'b00;
  logic uart_tx, tx_e_1, tx_e_2, mdc_1, mdc_2, clk_50_mhz_1, clk_50_mhz_2, rst_n_1, rst_n_2;
  logic [1:0] tx_d_1, tx_d_2;
  logic [7:0] led;
  wire mdio_1, mdio_2;
  int checks = 0, errors = 0;
  logic [1:0] q1[$], q2[$];
  logic [7:0] qb[$];
  logic mon_busy = 1'b0;
  logic [7:0] f1 = 8'd0, f2 = 8'd0;
  logic errf = 1'b0;
  eth_top #(.CLKS_PER_BIT(CB), .PHY_RST_CYCLES(1000), .BTN_SYNC_STAGES(2)) dut (
    .clk_200_mhz(clk), .rst(rst), .uart_tx(uart_tx), .uart_rx(uart_rx),
    .crs_dv_1(crs_dv_1), .crs_dv_2(crs_dv_2), .rx_er_1(rx_er_1), .rx_er_2(rx_er_2),
    .rx_d_1(rx_d_1), .rx_d_2(rx_d_2), .tx_d_1(tx_d_1), .tx_d_2(tx_d_2),
    .tx_e_1(tx_e_1), .tx_e_2(tx_e_2), .mdc_1(mdc_1), .mdc_2(mdc_2),
    .mdio_1(mdio_1), .mdio_2(mdio_2), .clk_50_mhz_1(clk_50_mhz_1), .clk_50_mhz_2(clk_50_mhz_2),
    .rst_n_1(rst_n_1), .rst_n_2(rst_n_2), .btn(btn), .led(led)
  );
  always #2.5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] exp_led();
    return {f2[3:0], f1[3:0]};
  endfunction
  initial forever begin
    @(posedge clk_50_mhz_1);
    @(posedge clk);
    #1;
    if (q2.size() != 0) begin
      chk("lane12_tx_e", tx_e_2, 1);
      chk("lane12_tx_d", tx_d_2, q2.pop_front());
    end else chk("lane12_idle", {tx_e_2, tx_d_2}, 0);
    if (q1.size() != 0) begin
      chk("lane21_tx_e", tx_e_1, 1);
      chk("lane21_tx_d", tx_d_1, q1.pop_front());
    end else chk("lane21_idle", {tx_e_1, tx_d_1}, 0);
  end
  initial begin : uart_mon
    int cur;
    logic [9:0] exp_f, got_a, got_b;
    logic unexp;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && !uart_tx) begin
        mon_busy = 1'b1;
        unexp = qb.size() == 0;
        exp_f = unexp ? 10'h000 : {1'b1, qb.pop_front(), 1'b0};
        cur = 0;
        for (int k = 0; k < 10; k++) begin
          repeat (k * CB + 1 - cur) @(posedge clk);
          #1;
          got_a[k] = uart_tx;
          repeat (CB - 3) @(posedge clk);
          #1;
          got_b[k] = uart_tx;
          cur = k * CB + CB - 2;
        end
        if (unexp) begin
          checks++;
          errors++;
          $display("FAIL uart_unexpected_byte: got %0h expected no byte", got_a[8:1]);
        end else begin
          chk("uart_frame_early", got_a, exp_f);
          chk("uart_frame_late", got_b, exp_f);
        end
        mon_busy = 1'b0;
      end
    end
  end
  task automatic send_frame(input int p, input int n, input logic [7:0] pat, input int er_at);
    logic [1:0] d;
    for (int i = 0; i < n; i++) begin
      @(posedge clk_50_mhz_1);
      #1;
      d = pat[2*i +: 2];
      if (p == 1) begin
        crs_dv_1 = 1'b1;
        rx_d_1 = d;
        rx_er_1 = i == er_at;
        q2.push_back(i == er_at ? RMII_ERR : d);
      end else begin
        crs_dv_2 = 1'b1;
        rx_d_2 = d;
        rx_er_2 = i == er_at;
        q1.push_back(i == er_at ? RMII_ERR : d);
      end
    end
    @(posedge clk_50_mhz_1);
    #1;
    {crs_dv_1, crs_dv_2, rx_er_1, rx_er_2, rx_d_1, rx_d_2} = '0;
    if (p == 1) f1++;
    else f2++;
    if (er_at >= 0) errf = 1'b1;
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (CB) @(posedge clk);
      #1;
    end
    uart_rx = 1'b1;
  endtask
  task automatic expect_report();
    qb.push_back(f1);
    qb.push_back(f2);
    qb.push_back({7'b0, errf});
  endtask
  task automatic pulse_btn();
    btn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    btn = 1'b0;
  endtask
  task automatic drain(input string name);
    int n;
    n = 0;
    while ((qb.size() != 0 || mon_busy) && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_pending"}, qb.size(), 0);
    repeat (12 * CB) @(posedge clk);
    #1;
    chk({name, "_quiet"}, mon_busy, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    realtime t0;
    repeat (100) @(posedge clk);
    #1;
    chk("reset_uart_tx", uart_tx, 1);
    chk("reset_tx", {tx_e_1, tx_e_2, tx_d_1, tx_d_2}, 0);
    chk("reset_led", led, 0);
    chk("reset_clk_mdc", {clk_50_mhz_1, clk_50_mhz_2, mdc_1, mdc_2}, 0);
    chk("reset_phy", {rst_n_1, rst_n_2}, 0);
    rst = 1'b0;
    n = 0;
    while (!rst_n_1 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("phy_rst_cycles", n, 1000);
    chk("phy_rst_2", rst_n_2, 1);
    @(posedge clk_50_mhz_2);
    t0 = $realtime;
    @(posedge clk_50_mhz_2);
    chk("clk50_period_ps", int'(($realtime - t0) * 1000.0), 20000);
    #1;
    chk("led_after_reset", led, 0);
    send_frame(1, 4, 8'hB5, -1);
    chk("led_one_frame", led, exp_led());
    repeat (17) send_frame(2, 1, 8'h03, -1);
    chk("led_port2_17", led, exp_led());
    repeat (255) send_frame(1, 1, 8'h02, -1);
    chk("frames1_wrap", dut.frames_1, f1);
    chk("led_after_wrap", led, exp_led());
    send_byte(CMD_CLEAR, 1'b1);
    f1 = 8'd0;
    f2 = 8'd0;
    errf = 1'b0;
    chk("led_clear", led, 0);
    repeat (2) send_frame(1, 2, 8'h0E, -1);
    repeat (3) send_frame(2, 3, 8'h2D, -1);
    chk("led_2_3", led, exp_led());
    expect_report();
    send_byte(CMD_STATUS, 1'b1);
    repeat (200) @(posedge clk);
    #1;
    pulse_btn();
    drain("report_2_3");
    send_byte(CMD_CLEAR, 1'b1);
    f1 = 8'd0;
    f2 = 8'd0;
    errf = 1'b0;
    chk("led_clear2", led, 0);
    send_frame(1, 4, 8'hB5, 2);
    chk("err_flag", dut.err_flag, errf);
    expect_report();
    send_byte(CMD_STATUS, 1'b1);
    drain("report_err");
    expect_report();
    pulse_btn();
    drain("report_btn");
    send_byte(CMD_CLEAR, 1'b0);
    repeat (2 * CB) @(posedge clk);
    #1;
    chk("bad_stop_ignored", led, exp_led());
    @(posedge clk_50_mhz_1);
    #1;
    crs_dv_1 = 1'b1;
    rx_d_1 = 2'b10;
    q2.push_back(2'b10);
    #10;
    chk("midframe_tx_e", tx_e_2, 1);
    rst = 1'b1;
    #1;
    f1 = 8'd0;
    f2 = 8'd0;
    errf = 1'b0;
    chk("rst_mid_tx_e", tx_e_2, 0);
    chk("rst_mid_led", led, exp_led());
    chk("rst_mid_phy", rst_n_1, 0);
    chk("rst_mid_frames", dut.frames_1, f1);
    repeat (10) @(posedge clk);
    #1;
    crs_dv_1 = 1'b0;
    rx_d_1 = 2'b00;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("lane_queues_empty", q1.size() + q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
